// File: rtl/sccb_pkg.sv
// rtl/sccb_pkg.sv - shared state encoding and register map constants for the SCCB target
package sccb_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PH_ID   = 3'd1,
    PH_SUB  = 3'd2,
    PH_DATA = 3'd3,
    PH_RD   = 3'd4,
    IGNORE  = 3'd5
  } sccb_state_t;

  localparam logic [7:0] ADDR_PID       = 8'h0A;
  localparam logic [7:0] ADDR_VER       = 8'h0B;
  localparam logic [7:0] ADDR_COM7      = 8'h12;
  localparam int         COM7_RESET_BIT = 7;

endpackage

// File: rtl/sccb_line_sync.sv
// rtl/sccb_line_sync.sv - 2-flop synchronizer and edge/START/STOP detection for sioc/siod
module sccb_line_sync (
  input  logic PCLK,
  input  logic PRESETN,
  input  logic sioc_in,
  input  logic siod_in,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_s
);

  // bit 0/1 synchronize, bit 2 holds the previous synchronized value
  logic [2:0] scl_q;
  logic [2:0] sda_q;

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      scl_q <= 3'b111;
      sda_q <= 3'b111;
    end else begin
      scl_q <= {scl_q[1:0], sioc_in};
      sda_q <= {sda_q[1:0], siod_in};
    end
  end

  assign scl_rise  = scl_q[1] & ~scl_q[2];
  assign scl_fall  = ~scl_q[1] & scl_q[2];
  assign start_det = scl_q[1] & scl_q[2] & sda_q[2] & ~sda_q[1];
  assign stop_det  = scl_q[1] & scl_q[2] & ~sda_q[2] & sda_q[1];
  assign sda_s     = sda_q[1];

endmodule

// File: rtl/sccb_target_regfile.sv
// rtl/sccb_target_regfile.sv - SCCB target emulating an OV7670 register file
// Optional bit-8 ACK drive enabled by defining SCCB_ACK_DRIVE_EN.
module sccb_target_regfile
  import sccb_pkg::*;
#(
  parameter logic [7:0] DEV_ID  = 8'h42,
  parameter logic [7:0] PID_VAL = 8'h76,
  parameter logic [7:0] VER_VAL = 8'h73
) (
  input  logic       PCLK,
  input  logic       PRESETN,
  input  logic       sioc_in,
  input  logic       siod_in,
  output logic       siod_oe,
  output logic       wr_stb,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       soft_rst,
  output logic       busy
);

  logic        scl_rise, scl_fall, start_det, stop_det, sda_s;
  sccb_state_t state_q, state_d;
  logic [3:0]  bit_cnt;
  logic [7:0]  shreg;
  logic [7:0]  ptr;
  logic [7:0]  regs [256];
  logic        oe_q;
  logic        oe_fall_d;
  logic [7:0]  rd_val;
  logic [7:0]  wr_val;
  logic        id_wr, id_rd, x_rise;

  sccb_line_sync u_sync (
    .PCLK      (PCLK),
    .PRESETN   (PRESETN),
    .sioc_in   (sioc_in),
    .siod_in   (siod_in),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det),
    .sda_s     (sda_s)
  );

  assign id_wr  = (shreg == DEV_ID);
  assign id_rd  = (shreg == (DEV_ID | 8'h01));
  assign x_rise = scl_rise && (bit_cnt == 4'd8);

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (stop_det) begin
      state_d = IDLE;
    end else if (start_det) begin
      state_d = PH_ID;
    end else if (x_rise) begin
      case (state_q)
        PH_ID:   state_d = id_wr ? PH_SUB : (id_rd ? PH_RD : IGNORE);
        PH_SUB:  state_d = PH_DATA;
        PH_DATA: state_d = IGNORE;
        PH_RD:   state_d = IGNORE;
        default: state_d = state_q;
      endcase
    end
  end

  // oe_fall_d is the drive level applied at the next sioc fall, keeping siod stable while sioc is high
  always_comb begin
    busy      = (state_q != IDLE);
    siod_oe   = oe_q;
    oe_fall_d = 1'b0;
    case (state_q)
      PH_RD:   oe_fall_d = (bit_cnt != 4'd8) && !rd_val[~bit_cnt[2:0]];
`ifdef SCCB_ACK_DRIVE_EN
      PH_ID:   oe_fall_d = (bit_cnt == 4'd8) && (id_wr || id_rd);
      PH_SUB:  oe_fall_d = (bit_cnt == 4'd8);
      PH_DATA: oe_fall_d = (bit_cnt == 4'd8);
`endif
      default: oe_fall_d = 1'b0;
    endcase
  end

  always_comb begin
    case (ptr)
      ADDR_PID: rd_val = PID_VAL;
      ADDR_VER: rd_val = VER_VAL;
      default:  rd_val = regs[ptr];
    endcase
    wr_val = shreg;
    if (ptr == ADDR_COM7) wr_val[COM7_RESET_BIT] = 1'b0;
  end

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      bit_cnt  <= 4'd0;
      shreg    <= 8'h00;
      ptr      <= 8'h00;
      oe_q     <= 1'b0;
      wr_stb   <= 1'b0;
      wr_addr  <= 8'h00;
      wr_data  <= 8'h00;
      soft_rst <= 1'b0;
      for (int i = 0; i < 256; i++) regs[i] <= 8'h00;
    end else begin
      wr_stb   <= 1'b0;
      soft_rst <= 1'b0;

      if (start_det || stop_det)
        bit_cnt <= 4'd0;
      else if (scl_rise && state_q != IDLE)
        bit_cnt <= (bit_cnt == 4'd8) ? 4'd0 : bit_cnt + 4'd1;

      if (scl_rise && bit_cnt != 4'd8) shreg <= {shreg[6:0], sda_s};

      if (state_q == PH_SUB && x_rise) ptr <= shreg;

      if (start_det || stop_det) oe_q <= 1'b0;
      else if (scl_fall)         oe_q <= oe_fall_d;

      if (soft_rst)
        for (int i = 0; i < 256; i++) regs[i] <= 8'h00;

      // the ID registers are read-only: such writes vanish without a strobe
      if (state_q == PH_DATA && x_rise && ptr != ADDR_PID && ptr != ADDR_VER) begin
        regs[ptr] <= wr_val;
        wr_stb    <= 1'b1;
        wr_addr   <= ptr;
        wr_data   <= shreg;
        soft_rst  <= (ptr == ADDR_COM7) && shreg[COM7_RESET_BIT];
      end
    end
  end

endmodule

// File: tb/tb_sccb_target_regfile.sv
// tb/tb_sccb_target_regfile.sv - directed self-checking bench for sccb_target_regfile
module tb_sccb_target_regfile;

  logic       PCLK;
  logic       PRESETN;
  logic       sioc_in, siod_in;
  logic       siod_oe, wr_stb, soft_rst, busy;
  logic [7:0] wr_addr, wr_data;
  logic       m_scl, m_sda;

  int checks = 0;
  int failures = 0;
  int stb_cnt = 0;
  int srst_cnt = 0;
  int oe_hi_cnt = 0;
  int viol_cnt = 0;

`ifdef SCCB_ACK_DRIVE_EN
  localparam logic ACK_EXP = 1'b1;
`else
  localparam logic ACK_EXP = 1'b0;
`endif

  sccb_target_regfile dut (
    .PCLK     (PCLK),
    .PRESETN  (PRESETN),
    .sioc_in  (sioc_in),
    .siod_in  (siod_in),
    .siod_oe  (siod_oe),
    .wr_stb   (wr_stb),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .soft_rst (soft_rst),
    .busy     (busy)
  );

  assign sioc_in = m_scl;
  assign siod_in = m_sda & ~siod_oe;

  initial PCLK = 1'b0;
  always #50 PCLK = ~PCLK;

  logic prev_scl = 1'b1, prev_oe = 1'b0, prev_rstn = 1'b0;
  always @(negedge PCLK) begin
    if (wr_stb)   stb_cnt++;
    if (soft_rst) srst_cnt++;
    if (siod_oe)  oe_hi_cnt++;
    if (PRESETN && prev_rstn && sioc_in && prev_scl && siod_oe !== prev_oe) viol_cnt++;
    prev_scl  = sioc_in;
    prev_oe   = siod_oe;
    prev_rstn = PRESETN;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic q();
    repeat (8) @(negedge PCLK);
  endtask

  task automatic bus_start();
    m_sda = 1'b1; q(); m_scl = 1'b1; q(); m_sda = 1'b0; q(); m_scl = 1'b0; q();
  endtask

  task automatic bus_stop();
    m_sda = 1'b0; q(); m_scl = 1'b1; q(); m_sda = 1'b1; q();
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      m_sda = b[i]; q(); m_scl = 1'b1; q(); q(); m_scl = 1'b0; q();
    end
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    send_bits(b, 8);
    m_sda = 1'b1; q(); m_scl = 1'b1; q(); ack = siod_oe; q(); m_scl = 1'b0; q();
  endtask

  task automatic read_byte(output logic [7:0] r, output logic x_oe);
    for (int i = 7; i >= 0; i--) begin
      m_sda = 1'b1; q(); m_scl = 1'b1; q(); r[i] = siod_in; q(); m_scl = 1'b0; q();
    end
    m_sda = 1'b1; q(); m_scl = 1'b1; q(); x_oe = siod_oe; q(); m_scl = 1'b0; q();
  endtask

  task automatic wr3(input logic [7:0] sub, input logic [7:0] data);
    logic a;
    bus_start();
    send_byte(8'h42, a);  chk("wr_ack_id", a, ACK_EXP);
    send_byte(sub, a);    chk("wr_ack_sub", a, ACK_EXP);
    send_byte(data, a);   chk("wr_ack_data", a, ACK_EXP);
    bus_stop();
  endtask

  task automatic set_ptr(input logic [7:0] sub);
    logic a;
    bus_start();
    send_byte(8'h42, a);  chk("ptr_ack_id", a, ACK_EXP);
    send_byte(sub, a);    chk("ptr_ack_sub", a, ACK_EXP);
    bus_stop();
  endtask

  task automatic rd_reg(input logic [7:0] sub, input logic [7:0] exp, input string tag);
    logic a, xo;
    logic [7:0] r;
    set_ptr(sub);
    bus_start();
    send_byte(8'h43, a);  chk("rd_ack_id", a, ACK_EXP);
    read_byte(r, xo);
    chk(tag, r, exp);
    chk("rd_bit8_released", xo, 1'b0);
    bus_stop();
  endtask

  initial begin
    int base_stb, base_oe;
    logic a, xo;
    logic [7:0] r;

    PRESETN = 1'b0;
    m_scl = 1'b1;
    m_sda = 1'b1;
    repeat (3) @(negedge PCLK);
    chk("rst_siod_oe", siod_oe, 1'b0);
    chk("rst_wr_stb", wr_stb, 1'b0);
    chk("rst_wr_addr", wr_addr, 8'h00);
    chk("rst_wr_data", wr_data, 8'h00);
    chk("rst_soft_rst", soft_rst, 1'b0);
    chk("rst_busy", busy, 1'b0);
    PRESETN = 1'b1;
    q();

    // 3-phase write, then read back
    bus_start();
    q();
    chk("busy_in_txn", busy, 1'b1);
    send_byte(8'h42, a);  chk("t1_ack_id", a, ACK_EXP);
    send_byte(8'h15, a);  chk("t1_ack_sub", a, ACK_EXP);
    send_byte(8'hA5, a);  chk("t1_ack_data", a, ACK_EXP);
    bus_stop();
    chk("t1_stb_count", stb_cnt, 1);
    chk("t1_wr_addr", wr_addr, 8'h15);
    chk("t1_wr_data", wr_data, 8'hA5);
    chk("t1_busy_after_stop", busy, 1'b0);
    rd_reg(8'h15, 8'hA5, "t1_readback");

    // ID registers
    rd_reg(8'h0A, 8'h76, "t2_pid");
    rd_reg(8'h0B, 8'h73, "t2_ver");
    wr3(8'h0A, 8'h55);
    chk("t2_ro_no_stb", stb_cnt, 1);
    rd_reg(8'h0A, 8'h76, "t2_pid_after_write");

    // COM7 soft reset
    wr3(8'h12, 8'h80);
    chk("t3_soft_rst_count", srst_cnt, 1);
    chk("t3_stb_count", stb_cnt, 2);
    rd_reg(8'h15, 8'h00, "t3_cleared_15");
    rd_reg(8'h12, 8'h00, "t3_com7_bit7");

    // unmatched device ID
    base_oe = oe_hi_cnt;
    bus_start();
    send_byte(8'h60, a);  chk("t4_no_ack_id", a, 1'b0);
    send_byte(8'h15, a);  chk("t4_no_ack_sub", a, 1'b0);
    send_byte(8'h99, a);  chk("t4_no_ack_data", a, 1'b0);
    bus_stop();
    chk("t4_no_stb", stb_cnt, 2);
    chk("t4_oe_never_high", oe_hi_cnt - base_oe, 0);

    // STOP after 4 data bits commits nothing
    wr3(8'h20, 8'h5A);
    chk("t5_setup_stb", stb_cnt, 3);
    bus_start();
    send_byte(8'h42, a);
    send_byte(8'h20, a);
    send_bits(8'hFF, 4);
    bus_stop();
    chk("t5_partial_no_stb", stb_cnt, 3);
    chk("t5_partial_busy", busy, 1'b0);
    rd_reg(8'h20, 8'h5A, "t5_partial_kept");

    // repeated START mid-PH_SUB leaves ptr alone and re-decodes the ID
    set_ptr(8'h0B);
    bus_start();
    send_byte(8'h42, a);
    send_bits(8'h0A, 4);
    bus_start();
    send_byte(8'h43, a);  chk("t5_rs_ack_id", a, ACK_EXP);
    read_byte(r, xo);
    chk("t5_rs_read", r, 8'h73);
    bus_stop();

    // reset while driving a 0 during a read
    set_ptr(8'h0A);
    bus_start();
    send_byte(8'h43, a);
    q();
    chk("t6_driving_low", siod_oe, 1'b1);
    @(negedge PCLK);
    PRESETN = 1'b0;
    #1;
    chk("t6_oe_released", siod_oe, 1'b0);
    chk("t6_busy", busy, 1'b0);
    chk("t6_wr_addr", wr_addr, 8'h00);
    chk("t6_wr_data", wr_data, 8'h00);
    chk("t6_wr_stb", wr_stb, 1'b0);
    chk("t6_soft_rst", soft_rst, 1'b0);
    repeat (4) @(negedge PCLK);
    PRESETN = 1'b1;
    q();
    base_stb = stb_cnt;
    send_byte(8'h42, a);  chk("t6_no_start_ack", a, 1'b0);
    send_byte(8'h15, a);
    send_byte(8'h99, a);
    bus_stop();
    chk("t6_no_start_no_stb", stb_cnt - base_stb, 0);
    chk("t6_no_start_busy", busy, 1'b0);

    chk("oe_stable_while_scl_high", viol_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
